// File: rtl/q65_bus_sequencer.sv
// Register-to-register bus sequencer: round-robin arbitration among NREQ requesters,
// then a drive / drive+load / ack sequence on one-hot register strobes.
module q65_bus_sequencer #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [NREQ-1:0]   reqValid,
  input  logic [3*NREQ-1:0] reqSrc,
  input  logic [3*NREQ-1:0] reqDst,
  output logic [NREQ-1:0]   reqAck,
  output logic [NREQ-1:0]   reqErr,
  output logic [7:0]        regEnableOut,
  output logic [7:0]        regLoadIn,
  output logic              busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_R = NREQ'(1);
  localparam logic [7:0]      ONE_8 = 8'd1;

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q, gnt_q;
  logic [2:0]      src_q, dst_q;
  logic [7:0]      en_q, ld_q;
  logic [NREQ-1:0] ack_q, err_q;
  logic            busy_q;

  logic            pick_vld;
  logic [IW-1:0]   pick, idx;
  logic [2:0]      pick_src, pick_dst;

  // Search starts one past the last grant; the last slot visited is the pointer itself.
  always_comb begin
    pick_vld = 1'b0;
    pick     = ptr_q;
    idx      = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr_q + IW'(k);
      if (!pick_vld && reqValid[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
    pick_src = reqSrc[3*pick +: 3];
    pick_dst = reqDst[3*pick +: 3];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ-1);
      gnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      en_q    <= '0;
      ld_q    <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            ptr_q  <= pick;
            gnt_q  <= pick;
            src_q  <= pick_src;
            dst_q  <= pick_dst;
            busy_q <= 1'b1;
            // A self-copy is rejected without ever touching the register bus.
            if (pick_src == pick_dst) begin
              state_q <= DONE;
              ack_q   <= ONE_R << pick;
              err_q   <= ONE_R << pick;
            end else begin
              state_q <= DRIVE;
              en_q    <= ONE_8 << pick_src;
            end
          end
        end
        DRIVE: begin
          state_q <= LOAD;
          ld_q    <= ONE_8 << dst_q;
        end
        LOAD: begin
          state_q <= DONE;
          en_q    <= '0;
          ld_q    <= '0;
          ack_q   <= ONE_R << gnt_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign regEnableOut = en_q;
  assign regLoadIn    = ld_q;
  assign reqAck       = ack_q;
  assign reqErr       = err_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_q65_bus_sequencer.sv
// Bench for q65_bus_sequencer: transaction-schedule model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters.
module tb_q65_bus_sequencer;
  logic        clk, resetN;
  logic [3:0]  reqValid;
  logic [11:0] reqSrc, reqDst;
  logic [3:0]  reqAck, reqErr;
  logic [7:0]  regEnableOut, regLoadIn;
  logic        busy;

  int tests = 0;
  int fails = 0;

  q65_bus_sequencer #(.NREQ(4)) dut (
    .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqSrc(reqSrc), .reqDst(reqDst),
    .reqAck(reqAck), .reqErr(reqErr), .regEnableOut(regEnableOut), .regLoadIn(regLoadIn),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] ld;
    logic [3:0] ack;
    logic [3:0] err;
    logic       busy;
  } exp_t;

  exp_t cur;
  exp_t sched[$];
  int   ptr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a grant expands into a fixed per-cycle output schedule.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sched.delete();
      cur = '0;
      ptr = 3;
    end else begin
      if (!cur.busy && sched.size() == 0 && |reqValid) begin
        int g, s, d;
        exp_t e;
        g = -1;
        for (int k = 1; k <= 4; k++)
          if (g < 0 && reqValid[(ptr + k) % 4]) g = (ptr + k) % 4;
        s = reqSrc[3*g +: 3];
        d = reqDst[3*g +: 3];
        ptr = g;
        if (s == d) begin
          e = '0; e.ack = 4'(1 << g); e.err = 4'(1 << g); e.busy = 1'b1; sched.push_back(e);
        end else begin
          e = '0; e.en = 8'(1 << s); e.busy = 1'b1; sched.push_back(e);
          e.ld = 8'(1 << d); sched.push_back(e);
          e = '0; e.ack = 4'(1 << g); e.busy = 1'b1; sched.push_back(e);
        end
      end
      cur = (sched.size() != 0) ? sched.pop_front() : exp_t'('0);
    end
  end

  always @(negedge clk) begin
    if (resetN)
      chk("model", {regEnableOut, regLoadIn, reqAck, reqErr, busy}, cur);
    tests++;
    assert ($onehot0(regEnableOut) && $onehot0(regLoadIn))
    else begin
      fails++;
      $display("FAIL onehot: en=%0h ld=%0h expected one-hot-or-zero", regEnableOut, regLoadIn);
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetN = 1'b0;
    @(negedge clk);
    #2 resetN = 1'b1;
  endtask

  task automatic set_req(input int i, input logic v, input int s, input int d);
    reqValid[i]       = v;
    reqSrc[3*i +: 3]  = 3'(s);
    reqDst[3*i +: 3]  = 3'(d);
  endtask

  logic [3:0] v;
  logic [2:0] sv [4];
  logic [2:0] dv [4];

  initial begin
    resetN = 1'b0; reqValid = '0; reqSrc = '0; reqDst = '0;
    repeat (2) nx();
    chk("reset_outputs", {regEnableOut, regLoadIn, reqAck, reqErr, busy}, 0);
    #2 resetN = 1'b1;

    // single transfer req0 1->2
    nx();
    set_req(0, 1'b1, 1, 2);
    nx(); chk("single_drive_en", regEnableOut, 8'h02); chk("single_drive_ld", regLoadIn, 8'h00);
    nx(); chk("single_load_en", regEnableOut, 8'h02); chk("single_load_ld", regLoadIn, 8'h04);
    nx(); chk("single_ack", reqAck, 4'b0001); reqValid = '0;
    nx(); chk("single_idle_busy", busy, 0);

    // contention from reset pointer
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, i, i + 4);
    for (int c = 1; c <= 19; c++) begin
      nx();
      chk("contend_ack", reqAck, (c % 4 == 3) ? (1 << ((c / 4) % 4)) : 0);
      chk("contend_busy", busy, (c % 4 != 0));
      if (c == 19) reqValid = '0;
    end

    // error: src == dst
    nx();
    set_req(2, 1'b1, 5, 5);
    nx(); chk("err_ack", reqAck, 4'b0100); chk("err_err", reqErr, 4'b0100);
    chk("err_buses", {regEnableOut, regLoadIn}, 0); reqValid = '0;
    nx(); chk("err_idle", busy, 0);
    set_req(2, 1'b1, 2, 6);
    for (int i = 0; i < 4; i++) reqValid[i] = 1'b1;
    nx(); chk("ptr_after_err_en", regEnableOut, 8'h08);
    nx(); chk("ptr_after_err_ld", regLoadIn, 8'h80);
    nx(); chk("ptr_after_err_ack", reqAck, 4'b1000); reqValid = '0;
    nx();

    // reset during LOAD
    set_req(1, 1'b1, 3, 6);
    set_req(3, 1'b1, 5, 7);
    nx(); chk("rst_drive_en", regEnableOut, 8'h08);
    nx(); chk("rst_load_ld", regLoadIn, 8'h40);
    #2 resetN = 1'b0;
    #1 chk("rst_outputs_zero", {regEnableOut, regLoadIn, reqAck, reqErr, busy}, 0);
    nx(); chk("rst_no_ack", reqAck, 0);
    #2 resetN = 1'b1;
    nx(); chk("rst_regrant_en", regEnableOut, 8'h08);
    nx(); chk("rst_regrant_ld", regLoadIn, 8'h40);
    nx(); chk("rst_regrant_ack", reqAck, 4'b0010); reqValid = '0;
    nx();

    // input change after grant
    set_req(3, 1'b1, 0, 7);
    nx(); chk("hold_drive_en", regEnableOut, 8'h01);
    set_req(3, 1'b1, 4, 2);
    nx(); chk("hold_load_en", regEnableOut, 8'h01); chk("hold_load_ld", regLoadIn, 8'h80);
    nx(); chk("hold_ack", reqAck, 4'b1000); reqValid = '0;
    nx();

    // randomized requesters
    v = '0;
    for (int i = 0; i < 4; i++) begin sv[i] = '0; dv[i] = '0; end
    for (int n = 0; n < 3000; n++) begin
      nx();
      for (int i = 0; i < 4; i++) begin
        if (reqAck[i]) v[i] = 1'b0;
        else if (!v[i]) begin
          if ($urandom_range(2) == 0) begin
            v[i]  = 1'b1;
            sv[i] = 3'($urandom_range(7));
            dv[i] = ($urandom_range(3) == 0) ? sv[i] : 3'($urandom_range(7));
          end
        end else begin
          if ($urandom_range(31) == 0) v[i] = 1'b0;
          if ($urandom_range(7) == 0) begin
            sv[i] = 3'($urandom_range(7));
            dv[i] = 3'($urandom_range(7));
          end
        end
        reqValid[i] = v[i];
        reqSrc[3*i +: 3] = sv[i];
        reqDst[3*i +: 3] = dv[i];
      end
      if ($urandom_range(299) == 0) begin
        #2 resetN = 1'b0;
        #1 chk("rand_rst_zero", {regEnableOut, regLoadIn, reqAck, reqErr, busy}, 0);
        nx();
        #2 resetN = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
